// File: rtl/zbuffer_depth_test_if.sv
// zbuffer_depth_test_if: fragment stream, depth/frame buffer ports and clear control
interface zbuffer_depth_test_if #(
  parameter int DATAWIDTH = 12,
  parameter int COLORWIDTH = 4,
  parameter int ADDRWIDTH = 15
);
  logic [ADDRWIDTH-1:0] i_addr;
  logic i_write_en;
  logic [DATAWIDTH-1:0] i_depth;
  logic [COLORWIDTH-1:0] i_color;
  logic clear_start;
  logic [ADDRWIDTH-1:0] zb_addr_read;
  logic [DATAWIDTH-1:0] zb_read_data;
  logic [ADDRWIDTH-1:0] zb_addr_write;
  logic zb_write_en;
  logic [DATAWIDTH-1:0] zb_write_data;
  logic [ADDRWIDTH-1:0] fb_addr_write;
  logic fb_write_en;
  logic [COLORWIDTH-1:0] fb_color;
  logic ready;
  logic clear_done;
  modport slave (
    input i_addr, i_write_en, i_depth, i_color, clear_start, zb_read_data,
    output zb_addr_read, zb_addr_write, zb_write_en, zb_write_data,
    output fb_addr_write, fb_write_en, fb_color, ready, clear_done
  );
  modport master (
    output i_addr, i_write_en, i_depth, i_color, clear_start, zb_read_data,
    input zb_addr_read, zb_addr_write, zb_write_en, zb_write_data,
    input fb_addr_write, fb_write_en, fb_color, ready, clear_done
  );
endinterface

// File: rtl/zbuffer_depth_test.sv
// zbuffer_depth_test: per-fragment depth test with forwarding, framebuffer write and buffer clear
module zbuffer_depth_test #(
  parameter int DATAWIDTH = 12,
  parameter int COLORWIDTH = 4,
  parameter int SCREEN_WIDTH = 160,
  parameter int SCREEN_HEIGHT = 160,
  parameter int ADDRWIDTH = $clog2(SCREEN_WIDTH*SCREEN_HEIGHT),
  parameter logic [COLORWIDTH-1:0] CLEAR_COLOR = '0
) (
  input logic clk,
  input logic rstn,
  zbuffer_depth_test_if.slave bus
);
  localparam int NPIX = SCREEN_WIDTH*SCREEN_HEIGHT;
  localparam logic [ADDRWIDTH-1:0] LAST = ADDRWIDTH'(NPIX-1);
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;
  state_t state;
  logic v1, v2, hv, we, rdy, start, accept, pass;
  logic [ADDRWIDTH-1:0] a1, ha, wa;
  logic [DATAWIDTH-1:0] d1, hd, wd, stored;
  logic [COLORWIDTH-1:0] c1, wc;
  assign rdy = rstn && state == IDLE && !v1 && !v2;
  assign start = bus.clear_start && rdy;
  assign accept = state == IDLE && !start && bus.i_write_en && int'(bus.i_addr) < NPIX;
  // the read issued last cycle misses both the write now on the outputs and the one just committed
  assign stored = (we && wa == a1) ? wd : (hv && ha == a1) ? hd : bus.zb_read_data;
  assign pass = d1 < stored;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      v1 <= 1'b0;
      v2 <= 1'b0;
      hv <= 1'b0;
      we <= 1'b0;
      wa <= '0;
      wd <= '0;
      wc <= '0;
    end else begin
      v1 <= accept;
      v2 <= v1;
      hv <= we && state == IDLE;
      ha <= wa;
      hd <= wd;
      if (accept) begin
        a1 <= bus.i_addr;
        d1 <= bus.i_depth;
        c1 <= bus.i_color;
      end
      if (state == CLEAR) begin
        if (wa == LAST) begin
          state <= DONE;
          we <= 1'b0;
        end else wa <= wa + ADDRWIDTH'(1);
      end else if (state == DONE) state <= IDLE;
      else if (start) begin
        state <= CLEAR;
        we <= 1'b1;
        wa <= '0;
        wd <= '1;
        wc <= CLEAR_COLOR;
        hv <= 1'b0;
      end else begin
        we <= v1 && pass;
        if (v1 && pass) begin
          wa <= a1;
          wd <= d1;
          wc <= c1;
        end
      end
    end
  end
  assign bus.zb_addr_read = bus.i_addr;
  assign bus.zb_addr_write = wa;
  assign bus.fb_addr_write = wa;
  assign bus.zb_write_en = we;
  assign bus.fb_write_en = we;
  assign bus.zb_write_data = wd;
  assign bus.fb_color = wc;
  assign bus.ready = rdy;
  assign bus.clear_done = state == DONE;
endmodule

// File: tb/tb_zbuffer_depth_test.sv
// tb_zbuffer_depth_test: random fragment stream against a sequential z-test model, plus clear/reset sequences
module tb_zbuffer_depth_test;
  localparam int W = 5, H = 4, NPIX = W*H, AW = $clog2(NPIX), DW = 12, CW = 4;
  localparam logic [CW-1:0] CCOL = 4'h9;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  zbuffer_depth_test_if #(.DATAWIDTH(DW), .COLORWIDTH(CW), .ADDRWIDTH(AW)) bus ();
  zbuffer_depth_test #(.DATAWIDTH(DW), .COLORWIDTH(CW), .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H),
    .CLEAR_COLOR(CCOL)) dut (.clk(clk), .rstn(rstn), .bus(bus));
  logic [DW-1:0] zmem [2**AW];
  logic [CW-1:0] fmem [2**AW];
  always @(posedge clk) begin
    bus.zb_read_data <= zmem[bus.zb_addr_read];
    if (bus.zb_write_en) zmem[bus.zb_addr_write] <= bus.zb_write_data;
    if (bus.fb_write_en) fmem[bus.fb_addr_write] <= bus.fb_color;
  end
  logic [DW-1:0] ref_z [NPIX];
  logic [CW-1:0] ref_c [NPIX];
  typedef struct packed {
    logic acc;
    logic we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } exp_t;
  exp_t exq[$];
  exp_t prev;
  int checks = 0, failures = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic pipe_empty;
    exq = {};
    exq.push_back('0);
    prev = '0;
  endtask
  // one fragment per cycle; the model applies the z-test in program order
  task automatic frag(input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [CW-1:0] c, input logic cs);
    exp_t e, o;
    logic rdy_exp;
    rdy_exp = !(prev.acc || exq[0].acc);
    chk("ready", bus.ready, rdy_exp);
    e = '0;
    if (en && int'(a) < NPIX) begin
      e.acc = 1'b1;
      if (d < ref_z[a]) begin
        ref_z[a] = d;
        ref_c[a] = c;
        e.we = 1'b1;
        e.a = a;
        e.d = d;
        e.c = c;
      end
    end
    bus.i_write_en = en;
    bus.i_addr = a;
    bus.i_depth = d;
    bus.i_color = c;
    bus.clear_start = cs && !rdy_exp;
    exq.push_back(e);
    step;
    o = exq.pop_front();
    prev = o;
    chk("zb_we", bus.zb_write_en, o.we);
    chk("fb_we", bus.fb_write_en, o.we);
    chk("clear_done", bus.clear_done, 0);
    if (o.we) begin
      chk("wr_addr", bus.zb_addr_write, o.a);
      chk("fb_addr", bus.fb_addr_write, o.a);
      chk("wr_depth", bus.zb_write_data, o.d);
      chk("wr_color", bus.fb_color, o.c);
    end
  endtask
  // clear is requested together with a fragment that must lose; fragments keep arriving throughout
  task automatic do_clear;
    bus.clear_start = 1'b1;
    bus.i_write_en = 1'b1;
    bus.i_addr = AW'($urandom_range(NPIX-1));
    bus.i_depth = '0;
    step;
    bus.clear_start = 1'b0;
    for (int k = 1; k <= NPIX + 1; k++) begin
      if (k <= NPIX) begin
        chk("clr_we", bus.zb_write_en, 1);
        chk("clr_fb_we", bus.fb_write_en, 1);
        chk("clr_addr", bus.zb_addr_write, k - 1);
        chk("clr_fb_addr", bus.fb_addr_write, k - 1);
        chk("clr_depth", bus.zb_write_data, 12'hFFF);
        chk("clr_color", bus.fb_color, CCOL);
        chk("clr_done_early", bus.clear_done, 0);
      end else begin
        chk("clr_done", bus.clear_done, 1);
        chk("clr_done_we", bus.zb_write_en, 0);
      end
      chk("clr_ready", bus.ready, 0);
      bus.i_write_en = 1'b1;
      bus.i_addr = AW'($urandom_range(NPIX-1));
      bus.i_depth = '0;
      bus.i_color = CW'($urandom);
      step;
    end
    bus.i_write_en = 1'b0;
    chk("clr_ready_after", bus.ready, 1);
    chk("clr_done_clear", bus.clear_done, 0);
    chk("clr_drop_we0", bus.zb_write_en, 0);
    step;
    chk("clr_drop_we1", bus.zb_write_en, 0);
    for (int i = 0; i < NPIX; i++) begin
      ref_z[i] = '1;
      ref_c[i] = CCOL;
    end
    pipe_empty();
  endtask
  task automatic rand_frags(input int n);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int i = 0; i < n; i++) begin
      a = ($urandom % 8 == 0) ? AW'($urandom_range(2**AW - 1, NPIX)) :
          ($urandom % 2 == 0) ? AW'($urandom_range(3)) : AW'($urandom_range(NPIX - 1));
      d = DW'($urandom);
      if ($urandom % 6 == 0 && int'(a) < NPIX) d = ref_z[a];
      frag($urandom % 5 != 0, a, d, CW'($urandom), $urandom % 4 == 0);
    end
    repeat (3) frag(1'b0, '0, '0, '0, 1'b0);
  endtask
  task automatic mem_compare;
    for (int i = 0; i < NPIX; i++) begin
      chk("zmem", zmem[i], ref_z[i]);
      chk("fmem", fmem[i], ref_c[i]);
    end
  endtask
  task automatic reset_mid_clear;
    bus.clear_start = 1'b1;
    step;
    bus.clear_start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      chk("rmc_addr", bus.zb_addr_write, k - 1);
      chk("rmc_we", bus.zb_write_en, 1);
      if (k == 7) rstn = 1'b0;
      step;
    end
    chk("rmc_we_drop", bus.zb_write_en, 0);
    chk("rmc_fb_we_drop", bus.fb_write_en, 0);
    chk("rmc_ready_low", bus.ready, 0);
    rstn = 1'b1;
    step;
    chk("rmc_ready", bus.ready, 1);
    chk("rmc_done", bus.clear_done, 0);
    chk("rmc_idle_we", bus.zb_write_en, 0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      zmem[i] = '0;
      fmem[i] = '0;
    end
    bus.i_write_en = 1'b1;
    bus.i_addr = '0;
    bus.i_depth = '0;
    bus.i_color = '0;
    bus.clear_start = 1'b1;
    step;
    step;
    chk("rst_zb_we", bus.zb_write_en, 0);
    chk("rst_fb_we", bus.fb_write_en, 0);
    chk("rst_done", bus.clear_done, 0);
    chk("rst_addr", bus.zb_addr_write, 0);
    chk("rst_fb_addr", bus.fb_addr_write, 0);
    chk("rst_depth", bus.zb_write_data, 0);
    chk("rst_color", bus.fb_color, 0);
    chk("rst_ready", bus.ready, 0);
    bus.clear_start = 1'b0;
    bus.i_write_en = 1'b0;
    rstn = 1'b1;
    step;
    chk("post_rst_ready", bus.ready, 1);
    chk("post_rst_we", bus.zb_write_en, 0);
    do_clear();
    frag(1'b1, 5, 100, 3, 1'b0);
    frag(1'b1, 9, 100, 1, 1'b0);
    frag(1'b1, 9, 200, 2, 1'b0);
    frag(1'b1, 10, 200, 1, 1'b0);
    frag(1'b1, 10, 100, 2, 1'b0);
    frag(1'b1, 7, 50, 4, 1'b0);
    frag(1'b1, 8, 60, 5, 1'b0);
    frag(1'b1, 7, 70, 6, 1'b0);
    frag(1'b1, 11, 100, 7, 1'b0);
    frag(1'b1, 11, 100, 8, 1'b0);
    frag(1'b1, 20, 0, 1, 1'b0);
    frag(1'b1, 31, 0, 1, 1'b0);
    frag(1'b1, 12, 300, 1, 1'b0);
    frag(1'b1, 13, 300, 2, 1'b1);
    frag(1'b1, 19, 1, 15, 1'b0);
    frag(1'b1, 19, 1, 14, 1'b0);
    frag(1'b1, 19, 0, 13, 1'b0);
    repeat (3) frag(1'b0, '0, '0, '0, 1'b0);
    mem_compare();
    rand_frags(600);
    mem_compare();
    reset_mid_clear();
    do_clear();
    mem_compare();
    rand_frags(300);
    mem_compare();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
